// File: rtl/btn_pkg.sv
// Shared definitions for the button debouncer array: repeat FSM state
// encoding, default timing constants and the repeat counter sizing helper.
package btn_pkg;

  // Repeat (typematic) FSM states, kept as plain constants so older blocks
  // that compare against raw codes keep working.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_RPT   = 2'd2;

  // Defaults used when a parent does not override the timing parameters.
  localparam int DEFAULT_DEPTH        = 3;
  localparam int DEFAULT_REPEAT_DELAY = 16;
  localparam int DEFAULT_REPEAT_RATE  = 4;

  // Width of the repeat counter: it is loaded with at most
  // max(delay, rate) - 1, and the extra bit keeps headroom so the value
  // is always representable without wrapping.
  function automatic int rpt_cnt_width(input int delay, input int rate);
    int longest;
    longest = (delay > rate) ? delay : rate;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/debouncer_array_if.sv
// Bundle of the sampling tick, raw button pins and all debounced outputs.
// The debouncer is the slave; the game logic / pin side is the master.
// The falling-transition pulse is called "released" because "release" is a
// reserved word in SystemVerilog.
interface debouncer_array_if #(
  parameter int N_CH = 4
);

  logic            sample_en;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] released;
  logic [N_CH-1:0] evt;

  modport master (
    output sample_en,
    output btn_in,
    input  level,
    input  press,
    input  released,
    input  evt
  );

  modport slave (
    input  sample_en,
    input  btn_in,
    output level,
    output press,
    output released,
    output evt
  );

endinterface

// File: rtl/debounce_channel.sv
// One debounced button: 2-flop synchroniser, DEPTH-sample agreement window,
// level/press/release generation and an optional auto-repeat FSM.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter bit PULSE_EN     = 1'b0,
  parameter bit REPEAT_EN    = 1'b0,
  parameter int REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEFAULT_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic btn,
  output logic level,
  output logic press,
  output logic released,
  output logic evt
);

  logic             sync_meta;
  logic             sync;
  logic [DEPTH-2:0] shift;
  logic [DEPTH-1:0] window;
  logic             rise;
  logic             fall;
  logic             rpt;

  // Bring the asynchronous pin into the clk domain on every clock,
  // regardless of the sampling tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync      <= sync_meta;
    end
  end

  // The window is the current synchronised sample plus the DEPTH-1 previous
  // ticks; only a unanimous window may move the debounced level.
  assign window = {shift, sync};
  assign rise   = sample_en && (&window) && !level;
  assign fall   = sample_en && !(|window) && level;

  // Shift in a new sample on each tick and update the debounced level;
  // press/release are re-evaluated every clock so they last exactly one clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift    <= '0;
      level    <= 1'b0;
      press    <= 1'b0;
      released <= 1'b0;
    end else begin
      press    <= rise;
      released <= fall;
      if (sample_en) begin
        shift <= window[DEPTH-2:0];
      end
      if (rise) begin
        level <= 1'b1;
      end else if (fall) begin
        level <= 1'b0;
      end
    end
  end

  generate
    if (REPEAT_EN) begin : g_rpt
      localparam int              CW         = rpt_cnt_width(REPEAT_DELAY, REPEAT_RATE);
      localparam logic [CW-1:0]   DELAY_LOAD = CW'(REPEAT_DELAY - 1);
      localparam logic [CW-1:0]   RATE_LOAD  = CW'(REPEAT_RATE - 1);

      logic [1:0]    state;
      logic [CW-1:0] cnt;
      logic          pulse;

      // Typematic timer: armed on the press edge, counts ticks down to zero,
      // fires a one-clk pulse and reloads with the repeat rate. A release
      // cancels it on the same edge without a final pulse. The counter only
      // decrements from a non-zero value, so it never wraps.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state <= ST_IDLE;
          cnt   <= '0;
          pulse <= 1'b0;
        end else begin
          pulse <= 1'b0;
          if (fall) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (rise) begin
            state <= ST_DELAY;
            cnt   <= DELAY_LOAD;
          end else if (state != ST_IDLE && state != ST_DELAY && state != ST_RPT) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (sample_en && state != ST_IDLE) begin
            if (cnt == '0) begin
              pulse <= 1'b1;
              cnt   <= RATE_LOAD;
              state <= ST_RPT;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
      end

      assign rpt = pulse;
    end else begin : g_no_rpt
      assign rpt = 1'b0;
    end
  endgenerate

  // Pulse channels report presses (and repeats); level channels mirror the
  // debounced state.
  assign evt = PULSE_EN ? (press | rpt) : level;

endmodule

// File: rtl/debouncer_array.sv
// Array of N_CH independent button debouncers sharing one sampling tick.
// Each channel picks level or pulse mode and optional auto-repeat through
// the per-channel bits of PULSE_MASK / REPEAT_MASK.
module debouncer_array
  import btn_pkg::*;
#(
  parameter int              N_CH         = 4,
  parameter int              DEPTH        = DEFAULT_DEPTH,
  parameter logic [N_CH-1:0] PULSE_MASK   = N_CH'(4'b0101),
  parameter logic [N_CH-1:0] REPEAT_MASK  = '0,
  parameter int              REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
  parameter int              REPEAT_RATE  = DEFAULT_REPEAT_RATE
) (
  input logic                    clk,
  input logic                    rst,
  debouncer_array_if.slave       bus
);

  logic [N_CH-1:0] level_vec;
  logic [N_CH-1:0] press_vec;
  logic [N_CH-1:0] released_vec;
  logic [N_CH-1:0] evt_vec;

  // Reject configurations the channel logic cannot implement.
  generate
    if (N_CH < 1) begin : g_bad_nch
      $error("debouncer_array: N_CH must be at least 1");
    end
    if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
      $error("debouncer_array: DEPTH must be in 2..16");
    end
    if (REPEAT_DELAY < 1) begin : g_bad_delay
      $error("debouncer_array: REPEAT_DELAY must be at least 1");
    end
    if (REPEAT_RATE < 1) begin : g_bad_rate
      $error("debouncer_array: REPEAT_RATE must be at least 1");
    end
  endgenerate

  // Auto-repeat only makes sense on pulse channels, so it is built only
  // where both mask bits are set.
  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
        .DEPTH        (DEPTH),
        .PULSE_EN     (PULSE_MASK[i]),
        .REPEAT_EN    (REPEAT_MASK[i] & PULSE_MASK[i]),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .sample_en (bus.sample_en),
        .btn       (bus.btn_in[i]),
        .level     (level_vec[i]),
        .press     (press_vec[i]),
        .released  (released_vec[i]),
        .evt       (evt_vec[i])
      );
    end
  endgenerate

  assign bus.level    = level_vec;
  assign bus.press    = press_vec;
  assign bus.released = released_vec;
  assign bus.evt      = evt_vec;

endmodule

// File: doc/debouncer_array.md
Name: debouncer_array

Overview:
- Parametrised successor to the fixed 4-button debouncer.
- Debounces N_CH independent button inputs with configurable sample depth.
- Each channel offers a level mode or a single-pulse mode, plus optional auto-repeat (typematic) while held.
- Sits between the board button pins and game control logic; sampling is paced by an external tick.

Parameters:
- N_CH, 4, number of button channels.
- DEPTH, 3, consecutive equal samples required to change debounced state (legal range 2..16).
- PULSE_MASK, 4'b0101, per channel: 1 = evt is a one-clk press pulse, 0 = evt follows the debounced level.
- REPEAT_MASK, 4'b0000, per channel: 1 = auto-repeat enabled (only meaningful where PULSE_MASK = 1).
- REPEAT_DELAY, 16, ticks from press to first repeat pulse (≥ 1).
- REPEAT_RATE, 4, ticks between subsequent repeat pulses (≥ 1).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-high.
- sample_en, in, 1: sampling tick, one clk wide (may be held high to sample every clk).
- btn_in, in, N_CH: raw asynchronous button inputs.
- level, out, N_CH: debounced button state.
- press, out, N_CH: one-clk pulse on a debounced rising transition.
- release, out, N_CH: one-clk pulse on a debounced falling transition.
- evt, out, N_CH: per-mode event output.

Behaviour:
- Reset: all outputs 0, synchronisers 0, sample shift registers 0, repeat counters 0, repeat FSM in IDLE. sample_en is ignored while rst is high.
- Input path: btn_in passes through a 2-flop synchroniser (sync) on every clk, independent of sample_en.
- Sampling: on each clk edge with sample_en = 1, window = {shift[DEPTH-2:0], sync}, and shift <= that window.
- Rising edge: if window is all ones and level = 0, then on that same edge level <= 1 and press <= 1.
- Falling edge: if window is all zeros and level = 1, then level <= 0 and release <= 1.
- Any mixed window leaves level unchanged. Glitches shorter than DEPTH ticks are rejected.
- Pulse width: press, release and the repeat pulse are high for exactly one clk. They are cleared on the next edge whether or not sample_en is set.
- Latency: a clean step on btn_in reaches level after 2 clk of synchroniser delay plus DEPTH ticks. level changes on the edge of the DEPTH-th consecutive matching tick.
- Repeat FSM (per channel; active only where REPEAT_MASK = 1):
  - IDLE -> DELAY on press; counter loaded with REPEAT_DELAY-1.
  - DELAY: decrement on each tick. At 0, emit a repeat pulse, reload REPEAT_RATE-1, go to RPT.
  - RPT: decrement on each tick. At 0, emit a repeat pulse and reload REPEAT_RATE-1.
  - From any state, level falling (release) -> IDLE, counter cleared, no pulse that cycle.
  - Counter width is $clog2(max(REPEAT_DELAY, REPEAT_RATE)) + 1; the counter never wraps.
- evt[i] = PULSE_MASK[i] ? (press[i] | rpt[i]) : level[i].
- Simultaneous events: channels are fully independent. A tick on which one channel presses and another releases produces both pulses on the same edge.
- Reset mid-press: after rst deasserts with a button held, a fresh press occurs after 2 clk + DEPTH ticks. No release pulse is generated by reset.
- sample_en held high continuously: sampling happens every clk, and repeat timing counts clk cycles.

Decomposition:
- Shared package btn_pkg:
  - Repeat FSM state encoding (IDLE, DELAY, RPT).
  - Default DEPTH/REPEAT constants.
  - A helper function for counter width.
- Natural sub-module: debounce_channel, covering one channel (synchroniser, shift register, level/press/release logic, repeat FSM). The top generates N_CH instances and slices the mask parameters per channel.
- Elaboration-time checks: DEPTH ≥ 2, REPEAT_DELAY ≥ 1, REPEAT_RATE ≥ 1.

Test Plan:
- Test-plan configuration: N_CH=4, DEPTH=3, PULSE_MASK=4'b0101, REPEAT_MASK=4'b0100, REPEAT_DELAY=4, REPEAT_RATE=2, sample_en every 8 clk.
- Clean press, ch1 (level mode): btn_in[1] held 1 -> level[1] and evt[1] rise on the 3rd tick after sync. press[1] is one clk wide. On release, level[1] falls after 3 zero ticks and release[1] is one clk wide.
- Bounce rejection, ch0: btn_in[0] toggles 1,0,1,1,0 across 5 ticks, then stays 0 -> level[0], press[0] and evt[0] never assert.
- Pulse mode, ch0: hold btn_in[0] for 20 ticks -> exactly one evt[0] pulse (no repeat on ch0). Then exactly one release[0] pulse after release.
- Auto-repeat, ch2: hold 12 ticks past the press -> evt[2] pulses at press, press+4, +6, +8, +10, +12 ticks. Release at press+5 instead -> pulses only at press and press+4, with no further pulses.
- Reset mid-operation and concurrency: assert rst while ch2 is in RPT -> all outputs 0 immediately, no release pulse. Hold ch0 and ch3 high together through rst deassert -> press[0] and press[3] fire on the same clk edge, 3 ticks after the synchroniser delay.
